// File: rtl/gpu_pkg.sv
// gpu_pkg: shared instruction field positions and dispatch FSM states
package gpu_pkg;
    localparam int INST_W    = 101;
    localparam int TYPE_BIT  = 0;
    localparam int VNUM_LSB  = 1;
    localparam int VNUM_MSB  = 3;
    localparam int ALPHA_LSB = 97;

    typedef enum logic [3:0] {
        IDLE, READ, LATCH, CHECK, WAIT_RDY, START, WAIT_DONE, ALPHA, ERR
    } disp_state_t;

    function automatic logic vnum_ok(input logic [VNUM_MSB-VNUM_LSB:0] vnum);
        return vnum inside {3'd2, 3'd3, 3'd4};
    endfunction
endpackage

// File: rtl/flex_counter.sv
// flex_counter: clearable up-counter that wraps to zero after rollover_val
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);
    logic [NUM_CNT_BITS-1:0] count_d, count_q;

    // next count: clear wins, then hold, then wrap or increment
    always_comb begin
        count_d = clear ? '0 : !count_enable ? count_q : (count_q == rollover_val) ? '0 : count_q + 1'b1;
    end

    // count register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_out = count_q;
endmodule

// File: rtl/instr_dispatch_ctrl.sv
// instr_dispatch_ctrl: pops, checks and dispatches one GPU instruction at a time
module instr_dispatch_ctrl
    import gpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 gpu_en,
    input  logic                 fifo_empty,
    input  logic [INST_W-1:0]    fifo_data,
    output logic                 fifo_read,
    output logic [INST_W-1:0]    inst_word,
    output logic                 inst_valid,
    input  logic                 raster_busy,
    output logic                 draw_start,
    input  logic                 draw_done,
    output logic                 alpha_load,
    input  logic                 clear_err,
    output logic                 ctrl_busy,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int TIMER_W = $clog2(TIMEOUT_CYC);

    disp_state_t          state_d, state_q;
    logic [INST_W-1:0]    inst_word_d, inst_word_q;
    logic                 fifo_read_d, fifo_read_q;
    logic                 inst_valid_d, inst_valid_q;
    logic                 draw_start_d, draw_start_q;
    logic                 alpha_load_d, alpha_load_q;
    logic                 ctrl_busy_d, ctrl_busy_q;
    logic                 err_flag_d, err_flag_q;
    logic [ERR_CNT_W-1:0] err_count_d, err_count_q;
    logic [TIMER_W-1:0]   timer;
    logic                 timeout;

    // watchdog: zeroed while starting the draw, counts every WAIT_DONE cycle
    flex_counter #(.NUM_CNT_BITS(TIMER_W)) u_watchdog (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (state_q == START),
        .count_enable(state_q == WAIT_DONE),
        .rollover_val(TIMER_W'(TIMEOUT_CYC - 1)),
        .count_out   (timer)
    );

    assign timeout = timer == TIMER_W'(TIMEOUT_CYC - 1);

    // next state plus Moore outputs decoded from the state being entered
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = (gpu_en && !fifo_empty) ? READ : IDLE;
            READ:      state_d = LATCH;
            LATCH:     state_d = CHECK;
            CHECK:     state_d = inst_word_q[TYPE_BIT] ? ALPHA :
                                 vnum_ok(inst_word_q[VNUM_MSB:VNUM_LSB]) ? WAIT_RDY : ERR;
            WAIT_RDY:  state_d = raster_busy ? WAIT_RDY : START;
            START:     state_d = WAIT_DONE;
            WAIT_DONE: state_d = draw_done ? IDLE : timeout ? ERR : WAIT_DONE;
            default:   state_d = IDLE;
        endcase
        inst_word_d  = (state_q == LATCH) ? fifo_data : inst_word_q;
        fifo_read_d  = state_d == READ;
        draw_start_d = state_d == START;
        alpha_load_d = state_d == ALPHA;
        inst_valid_d = state_d inside {WAIT_RDY, START, WAIT_DONE, ALPHA};
        ctrl_busy_d  = state_d != IDLE;
        err_flag_d   = clear_err ? 1'b0 : (err_flag_q | (state_q == ERR));
        err_count_d  = clear_err ? '0 :
                       (state_q == ERR && err_count_q != '1) ? err_count_q + 1'b1 : err_count_q;
    end

    // FSM, held instruction, registered outputs and error bookkeeping
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            inst_word_q  <= '0;
            fifo_read_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            draw_start_q <= 1'b0;
            alpha_load_q <= 1'b0;
            ctrl_busy_q  <= 1'b0;
            err_flag_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            inst_word_q  <= inst_word_d;
            fifo_read_q  <= fifo_read_d;
            inst_valid_q <= inst_valid_d;
            draw_start_q <= draw_start_d;
            alpha_load_q <= alpha_load_d;
            ctrl_busy_q  <= ctrl_busy_d;
            err_flag_q   <= err_flag_d;
            err_count_q  <= err_count_d;
        end
    end

    assign fifo_read  = fifo_read_q;
    assign inst_word  = inst_word_q;
    assign inst_valid = inst_valid_q;
    assign draw_start = draw_start_q;
    assign alpha_load = alpha_load_q;
    assign ctrl_busy  = ctrl_busy_q;
    assign err_flag   = err_flag_q;
    assign err_count  = err_count_q;
endmodule

// File: tb/tb_instr_dispatch_ctrl.sv
// tb_instr_dispatch_ctrl: scoreboard bench for the instruction dispatcher
module tb_instr_dispatch_ctrl;
    logic         clk = 0, n_rst = 0, gpu_en = 0, fifo_empty = 1;
    logic         raster_busy = 0, draw_done = 0, clear_err = 0;
    logic [100:0] fifo_data = '0;
    logic         fifo_read, inst_valid, draw_start, alpha_load, ctrl_busy, err_flag;
    logic [100:0] inst_word;
    logic [7:0]   err_count;

    instr_dispatch_ctrl dut (
        .clk(clk), .n_rst(n_rst), .gpu_en(gpu_en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_read(fifo_read), .inst_word(inst_word),
        .inst_valid(inst_valid), .raster_busy(raster_busy), .draw_start(draw_start),
        .draw_done(draw_done), .alpha_load(alpha_load), .clear_err(clear_err),
        .ctrl_busy(ctrl_busy), .err_flag(err_flag), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // event kinds: 0 pop, 1 alpha_load, 2 draw_start, 3 error-count increment
    typedef struct {int kind; int cyc; int data;} ev_t;
    ev_t          exp_q[$];
    logic [100:0] fifo_q[$];
    int           checks = 0, failures = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic expect_ev(input int k, input int c, input int d);
        exp_q.push_back('{k, c, d});
    endtask

    function automatic logic [100:0] mk(input bit typ, input int vn, input int al);
        logic [100:0] w;
        w = '0;
        w[0] = typ;
        w[3:1] = vn[2:0];
        w[100:97] = al[3:0];
        return w;
    endfunction

    task automatic push(input logic [100:0] w);
        fifo_q.push_back(w);
        fifo_empty = 0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        repeat (2) @(negedge clk);
        while (ctrl_busy && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", ctrl_busy, 0);
    endtask

    task automatic pulse_done();
        draw_done = 1;
        @(negedge clk);
        draw_done = 0;
    endtask

    task automatic got(input int k, input int d);
        ev_t e;
        if (exp_q.size() == 0) chk($sformatf("unexpected_ev%0d", k), cyc, -1);
        else begin
            e = exp_q.pop_front();
            chk($sformatf("ev%0d_kind", k), k, e.kind);
            chk($sformatf("ev%0d_cycle", k), cyc, e.cyc);
            chk($sformatf("ev%0d_data", k), d, e.data);
        end
    endtask

    // command FIFO model: hands the next word over during the pop cycle
    initial forever begin
        @(negedge clk);
        if (n_rst && fifo_read) begin
            chk("pop_nonempty", fifo_q.size() > 0, 1);
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            fifo_empty = fifo_q.size() == 0;
        end
    end

    // monitor: every observed output event must match the scoreboard head
    int prev_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (!n_rst) prev_cnt = 0;
        else begin
            if (fifo_read)  got(0, 0);
            if (alpha_load) got(1, int'(inst_word[100:97]));
            if (draw_start) got(2, int'(inst_word[3:1]));
            if (int'(err_count) != prev_cnt && err_count != 0) got(3, int'(err_count));
            prev_cnt = int'(err_count);
        end
    end

    initial begin
        int n;
        #1;
        chk("rst_fifo_read", fifo_read, 0);
        chk("rst_inst_word", inst_word, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_ctrl_busy", ctrl_busy, 0);
        chk("rst_err_count", err_count, 0);
        repeat (2) @(negedge clk);
        n_rst = 1;
        gpu_en = 1;
        @(negedge clk);
        pulse_done();
        repeat (2) @(negedge clk);
        chk("stray_done_ignored", ctrl_busy, 0);

        // draw vnum=3, done after 10 WAIT_DONE cycles
        n = cyc;
        expect_ev(0, n + 1, 0);
        expect_ev(2, n + 5, 3);
        push(mk(0, 3, 0));
        wait_until(n + 15);
        chk("draw_inst_valid", inst_valid, 1);
        pulse_done();
        wait_idle(50);
        chk("draw_no_err", err_flag, 0);
        chk("idle_inst_valid", inst_valid, 0);

        // alpha word
        n = cyc;
        expect_ev(0, n + 1, 0);
        expect_ev(1, n + 4, 10);
        push(mk(1, 0, 10));
        wait_until(n + 6);
        chk("alpha_field_held", inst_word[100:97], 4'hA);
        wait_idle(50);

        // bad vnum then a good one back to back
        n = cyc;
        expect_ev(0, n + 1, 0);
        expect_ev(3, n + 5, 1);
        expect_ev(0, n + 6, 0);
        expect_ev(2, n + 10, 2);
        push(mk(0, 1, 0));
        push(mk(0, 2, 0));
        wait_until(n + 6);
        chk("bad_vnum_flag", err_flag, 1);
        wait_until(n + 13);
        pulse_done();
        wait_idle(50);

        // raster busy for 20 cycles, then watchdog timeout
        raster_busy = 1;
        n = cyc;
        expect_ev(0, n + 1, 0);
        expect_ev(2, n + 25, 4);
        expect_ev(3, n + 4123, 2);
        push(mk(0, 4, 0));
        wait_until(n + 20);
        chk("busy_hold_ctrl", ctrl_busy, 1);
        chk("busy_hold_valid", inst_valid, 1);
        wait_until(n + 24);
        raster_busy = 0;
        wait_idle(5000);

        // done exactly on the terminal timer cycle
        n = cyc;
        expect_ev(0, n + 1, 0);
        expect_ev(2, n + 5, 3);
        push(mk(0, 3, 0));
        wait_until(n + 4101);
        pulse_done();
        wait_idle(50);
        chk("terminal_done_cnt", err_count, 2);

        // clear_err in the same cycle as an error event
        n = cyc;
        expect_ev(0, n + 1, 0);
        push(mk(0, 0, 0));
        wait_until(n + 4);
        clear_err = 1;
        @(negedge clk);
        clear_err = 0;
        wait_idle(50);
        chk("clear_prio_cnt", err_count, 0);
        chk("clear_prio_flag", err_flag, 0);

        // 256 errors saturate the counter
        n = cyc;
        for (int i = 0; i < 256; i++) begin
            expect_ev(0, n + 1 + 5 * i, 0);
            if (i < 255) expect_ev(3, n + 5 + 5 * i, i + 1);
            push(mk(0, 7, 0));
        end
        wait_until(n + 5 * 256 + 2);
        wait_idle(50);
        chk("sat_cnt", err_count, 255);

        // reset during WAIT_DONE
        n = cyc;
        expect_ev(0, n + 1, 0);
        expect_ev(2, n + 5, 2);
        push(mk(0, 2, 0));
        wait_until(n + 8);
        chk("sb_drained_pre_rst", exp_q.size(), 0);
        n_rst = 0;
        #1;
        chk("mid_rst_busy", ctrl_busy, 0);
        chk("mid_rst_valid", inst_valid, 0);
        chk("mid_rst_word", inst_word, 0);
        chk("mid_rst_cnt", err_count, 0);
        chk("mid_rst_flag", err_flag, 0);
        repeat (2) @(negedge clk);
        n_rst = 1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", ctrl_busy, 0);

        // gpu_en low blocks pops; dropping it mid-instruction lets it finish
        gpu_en = 0;
        push(mk(0, 3, 0));
        repeat (10) @(negedge clk);
        chk("gated_busy", ctrl_busy, 0);
        n = cyc;
        expect_ev(0, n + 1, 0);
        expect_ev(2, n + 5, 3);
        gpu_en = 1;
        wait_until(n + 6);
        gpu_en = 0;
        push(mk(1, 0, 5));
        wait_until(n + 8);
        pulse_done();
        wait_idle(50);
        repeat (5) @(negedge clk);
        chk("gated_after_done", ctrl_busy, 0);

        // two queued alpha words: one pop each
        n = cyc;
        expect_ev(0, n + 1, 0);
        expect_ev(1, n + 4, 5);
        expect_ev(0, n + 6, 0);
        expect_ev(1, n + 9, 6);
        push(mk(1, 0, 6));
        gpu_en = 1;
        wait_until(n + 10);
        wait_idle(50);
        repeat (5) @(negedge clk);
        chk("sb_drained_end", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end
endmodule
